// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// stall timeout and a packed legacy control bus for the existing datapath.
module unidad_control_multiciclo #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUCTL_W = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  ir_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  reg_dst,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic [ALUCTL_W-1:0]   alu_control,
    output logic [ALUCTL_W+2:0]   ctrl_bus,
    output logic [2:0]            state_o,
    output logic                  instr_done,
    output logic                  illegal_op,
    output logic                  mem_timeout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

    state_t               state;
    logic [OPCODE_W-1:0]  op_q;
    logic [FUNCT_W-1:0]   fn_q;
    logic [CNT_W-1:0]     wait_cnt;

    function automatic logic r_legal(input logic [FUNCT_W-1:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic legal(input logic [OPCODE_W-1:0] o,
                                   input logic [FUNCT_W-1:0]  f);
        return ((o == OP_R) && r_legal(f)) || (o == OP_LW) ||
               (o == OP_SW) || (o == OP_BEQ) || (o == OP_ADDI);
    endfunction

    function automatic logic [ALUCTL_W-1:0] alu_of(
        input logic [OPCODE_W-1:0] o,
        input logic [FUNCT_W-1:0]  f
    );
        logic [ALUCTL_W-1:0] c;
        c = ALU_ADD;
        if (o == OP_BEQ) begin
            c = ALU_SUB;
        end else if (o == OP_R) begin
            unique case (1'b1)
                f == FN_SUB: c = ALU_SUB;
                f == FN_AND: c = ALU_AND;
                f == FN_OR:  c = ALU_OR;
                f == FN_SLT: c = ALU_SLT;
                default:     c = ALU_ADD;
            endcase
        end
        return c;
    endfunction

    logic is_r, is_lw, is_sw, is_beq, is_addi;
    logic stall, timeout, dec_legal;

    assign is_r    = (op_q == OP_R);
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_beq  = (op_q == OP_BEQ);
    assign is_addi = (op_q == OP_ADDI);

    assign stall     = ((state == FETCH) || (state == MEM)) && !mem_ready;
    assign timeout   = stall && (MAX_WAIT != 0) && (wait_cnt == LIMIT);
    assign dec_legal = legal(opcode, funct);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            fn_q     <= '0;
            wait_cnt <= '0;
        end else begin
            // Leaving a memory state, a handshake or a timeout all restart the count.
            if (stall && !timeout) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            unique case (state)
                IDLE:   state <= FETCH;
                FETCH:  state <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    op_q  <= opcode;
                    fn_q  <= funct;
                    state <= dec_legal ? EXEC : FETCH;
                end
                EXEC: begin
                    if (is_lw || is_sw) state <= MEM;
                    else if (is_r || is_addi) state <= WB;
                    else state <= FETCH;
                end
                MEM: begin
                    if (mem_ready) state <= is_lw ? WB : FETCH;
                    else if (timeout) state <= FETCH;
                end
                WB:      state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        alu_control   = '0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        unique case (state)
            FETCH: begin
                mem_read    = 1'b1;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
                mem_timeout = timeout;
            end
            DECODE: illegal_op = !dec_legal;
            EXEC: begin
                alu_control   = alu_of(op_q, fn_q);
                alu_src       = is_lw || is_sw || is_addi;
                pc_write_cond = is_beq;
                instr_done    = is_beq;
            end
            MEM: begin
                alu_control = ALU_ADD;
                mem_read    = is_lw;
                mem_write   = is_sw;
                instr_done  = is_sw && mem_ready;
                mem_timeout = timeout;
            end
            WB: begin
                alu_control = alu_of(op_q, fn_q);
                reg_write   = 1'b1;
                reg_dst     = is_r;
                mem_to_reg  = is_lw;
                instr_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl_bus = {reg_write, alu_control, mem_write, mem_to_reg};
    assign state_o  = state;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: per-cycle expected output
// vectors are queued as stimulus is applied and checked against the DUT.
module tb_unidad_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, alu_src, reg_write;
    logic [2:0] alu_control;
    logic [5:0] ctrl_bus;
    logic [2:0] state_o;
    logic       instr_done, illegal_op, mem_timeout;

    unidad_control_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src(alu_src),
        .reg_write(reg_write), .alu_control(alu_control),
        .ctrl_bus(ctrl_bus), .state_o(state_o), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // flag bits: pcw pcc irw mr mw m2r rd as rw
    localparam logic [8:0] PCW = 9'b100000000;
    localparam logic [8:0] PCC = 9'b010000000;
    localparam logic [8:0] IRW = 9'b001000000;
    localparam logic [8:0] MR  = 9'b000100000;
    localparam logic [8:0] MW  = 9'b000010000;
    localparam logic [8:0] M2R = 9'b000001000;
    localparam logic [8:0] RD  = 9'b000000100;
    localparam logic [8:0] AS  = 9'b000000010;
    localparam logic [8:0] RW  = 9'b000000001;
    localparam logic [2:0] DN  = 3'b100;
    localparam logic [2:0] IL  = 3'b010;
    localparam logic [2:0] TO  = 3'b001;

    typedef struct {
        string       tag;
        logic [23:0] v;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total = 0;

    function automatic logic [23:0] mk(input logic [2:0] st,
                                       input logic [8:0] f,
                                       input logic [2:0] alu,
                                       input logic [2:0] ev);
        logic [5:0] bus;
        bus = {f[0], alu, f[4], f[3]};
        return {st, f, alu, ev, bus};
    endfunction

    function automatic logic [23:0] observed();
        return {state_o, pc_write, pc_write_cond, ir_write, mem_read,
                mem_write, mem_to_reg, reg_dst, alu_src, reg_write,
                alu_control, instr_done, illegal_op, mem_timeout,
                ctrl_bus};
    endfunction

    task automatic step(input string tag, input logic rst,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic [23:0] e);
        exp_t x;
        exp_t y;
        logic [23:0] o;
        @(negedge clk);
        rst_n     = rst;
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
        #1;
        y = sb.pop_front();
        o = observed();
        total++;
        assert (o === y.v) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", y.tag, o, y.v);
    endtask

    task automatic fetch_ok(input string tag);
        step(tag, 1, 6'h00, 6'h00, 1, mk(3'd1, MR | IRW | PCW, 3'b000, 3'b000));
    endtask

    logic [23:0] zero;
    logic [5:0]  bus_o;

    initial begin
        zero = '0;
        for (int i = 0; i < 3; i++)
            step("reset", 0, 6'h00, 6'h00, 0, zero);
        step("idle", 1, 6'h00, 6'h00, 0, zero);
        step("fetch_wait", 1, 6'h00, 6'h00, 0, mk(3'd1, MR, 3'b000, 3'b000));
        fetch_ok("fetch_add");

        step("dec_add", 1, 6'b000000, 6'b100000, 0, zero | 24'h400000);
        step("exec_add", 1, 6'h3f, 6'h3f, 0, mk(3'd3, 9'd0, 3'b010, 3'b000));
        step("wb_add", 1, 6'h00, 6'h00, 0, mk(3'd5, RW | RD, 3'b010, DN));
        bus_o = ctrl_bus;
        total++;
        assert (bus_o === 6'b1_010_0_0) pass_cnt++;
        else $error("FAIL wb_add_bus observed=%b expected=%b", bus_o, 6'b101000);

        fetch_ok("fetch_lw");
        step("dec_lw", 1, 6'b100011, 6'h00, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_lw", 1, 6'h00, 6'h00, 0, mk(3'd3, AS, 3'b010, 3'b000));
        step("mem_lw0", 1, 6'h00, 6'h00, 0, mk(3'd4, MR, 3'b010, 3'b000));
        step("mem_lw1", 1, 6'h00, 6'h00, 0, mk(3'd4, MR, 3'b010, 3'b000));
        step("mem_lw2", 1, 6'h00, 6'h00, 1, mk(3'd4, MR, 3'b010, 3'b000));
        step("wb_lw", 1, 6'h00, 6'h00, 0, mk(3'd5, RW | M2R, 3'b010, DN));

        fetch_ok("fetch_sw");
        step("dec_sw", 1, 6'b101011, 6'h00, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_sw", 1, 6'h00, 6'h00, 0, mk(3'd3, AS, 3'b010, 3'b000));
        step("mem_sw", 1, 6'h00, 6'h00, 1, mk(3'd4, MW, 3'b010, DN));

        fetch_ok("fetch_beq");
        step("dec_beq", 1, 6'b000100, 6'h00, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_beq", 1, 6'h00, 6'h00, 0, mk(3'd3, PCC, 3'b110, DN));

        fetch_ok("fetch_ill1");
        step("dec_ill_op", 1, 6'b111111, 6'h00, 0, mk(3'd2, 9'd0, 3'b000, IL));
        fetch_ok("fetch_ill2");
        step("dec_ill_fn", 1, 6'b000000, 6'b000001, 0, mk(3'd2, 9'd0, 3'b000, IL));
        fetch_ok("fetch_addi");
        step("dec_addi", 1, 6'b001000, 6'h00, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_addi", 1, 6'h00, 6'h00, 0, mk(3'd3, AS, 3'b010, 3'b000));
        step("wb_addi", 1, 6'h00, 6'h00, 0, mk(3'd5, RW, 3'b010, DN));

        fetch_ok("fetch_sub");
        step("dec_sub", 1, 6'b000000, 6'b100010, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_sub", 1, 6'h00, 6'h00, 0, mk(3'd3, 9'd0, 3'b110, 3'b000));
        step("wb_sub", 1, 6'h00, 6'h00, 0, mk(3'd5, RW | RD, 3'b110, DN));
        fetch_ok("fetch_slt");
        step("dec_slt", 1, 6'b000000, 6'b101010, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_slt", 1, 6'h00, 6'h00, 0, mk(3'd3, 9'd0, 3'b111, 3'b000));
        step("wb_slt", 1, 6'h00, 6'h00, 0, mk(3'd5, RW | RD, 3'b111, DN));

        for (int i = 0; i < 14; i++)
            step("fetch_stall", 1, 6'h00, 6'h00, 0, mk(3'd1, MR, 3'b000, 3'b000));
        step("fetch_timeout", 1, 6'h00, 6'h00, 0, mk(3'd1, MR, 3'b000, TO));
        step("fetch_after_to", 1, 6'h00, 6'h00, 0, mk(3'd1, MR, 3'b000, 3'b000));
        fetch_ok("fetch_lw_to");
        step("dec_lw_to", 1, 6'b100011, 6'h00, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_lw_to", 1, 6'h00, 6'h00, 0, mk(3'd3, AS, 3'b010, 3'b000));
        for (int i = 0; i < 14; i++)
            step("mem_stall", 1, 6'h00, 6'h00, 0, mk(3'd4, MR, 3'b010, 3'b000));
        step("mem_timeout", 1, 6'h00, 6'h00, 0, mk(3'd4, MR, 3'b010, TO));
        step("fetch_after_mto", 1, 6'h00, 6'h00, 0, mk(3'd1, MR, 3'b000, 3'b000));

        fetch_ok("fetch_sw_rst");
        step("dec_sw_rst", 1, 6'b101011, 6'h00, 0, mk(3'd2, 9'd0, 3'b000, 3'b000));
        step("exec_sw_rst", 1, 6'h00, 6'h00, 0, mk(3'd3, AS, 3'b010, 3'b000));
        step("mem_sw_rst", 1, 6'h00, 6'h00, 0, mk(3'd4, MW, 3'b010, 3'b000));
        step("rst_mid_sw", 0, 6'h00, 6'h00, 0, zero);
        step("idle_again", 1, 6'h00, 6'h00, 0, zero);
        step("fetch_again", 1, 6'h00, 6'h00, 0, mk(3'd1, MR, 3'b000, 3'b000));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
